fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 imem_req  output  1  instruction-memory read request.
REQ-005 imem_addr  output  32  word address of request (equals pc).
REQ-006 imem_ack  input  1  memory returns imem_rdata this cycle.
REQ-007 imem_rdata  input  32  fetched instruction word.
REQ-008 instr  output  32  registered instruction handed to decode/controller.
REQ-009 instr_valid  output  1  instr, pc and pc_plus4 are valid.
REQ-010 instr_ready  input  1  decode/controller accepts instr.
REQ-011 pc, pc_plus4  output  32 each  address of issued instruction and address+4.
REQ-012 resolve_valid  input  1  execute stage presents control outcome for the issued instruction.
REQ-013 Jump, Branch, Jalr  input  1 each  controller decode of the issued instruction.
REQ-014 func3  input  3  branch condition select.
REQ-015 Zero, Neg  input  1 each  ALU result-zero and result-negative flags.
REQ-016 ImmExt, ALUResult  input  32 each  extended immediate; ALU output (jalr target).
REQ-017 misaligned  output  1  sticky flag: computed target not word-aligned.
REQ-018 retired  output  32  count of resolved instructions.

Function
REQ-019 States: FETCH, WAIT_MEM, ISSUE, RESOLVE, HALT; one instruction in flight.
REQ-020 FETCH: imem_req=1, imem_addr=pc; imem_ack=1 -> capture imem_rdata into instr, go ISSUE; else go WAIT_MEM.
REQ-021 WAIT_MEM: imem_req held 1, imem_addr stable; go ISSUE on the cycle after imem_ack=1, capturing imem_rdata.
REQ-022 imem_req is 0 in ISSUE, RESOLVE and HALT; imem_ack outside FETCH/WAIT_MEM is ignored.
REQ-023 ISSUE: instr_valid=1; instr, pc, pc_plus4 stable until instr_valid&instr_ready; on that edge go RESOLVE.
REQ-024 RESOLVE: instr_valid=0; wait for resolve_valid=1; resolve_valid in any other state is ignored.
REQ-025 Branch taken: func3 000 Zero; 001 !Zero; 100 Neg; 101 !Neg; any other func3 not taken.
REQ-026 Next PC priority: Jalr -> {ALUResult[31:1],1'b0}; else Jump or taken Branch -> pc+ImmExt; else pc_plus4.
REQ-027 All PC arithmetic modulo 2^32; wrap-around from 32'hFFFF_FFFC to 0 is silent.
REQ-028 On resolve_valid in RESOLVE: retired increments by 1 (wraps at 2^32); if next PC [1:0]==0, load pc and go FETCH; else set misaligned, leave pc unchanged, go HALT.
REQ-029 HALT is terminal until reset; misaligned stays 1; no requests issued.
REQ-030 Minimum instruction period with zero-wait memory and same-cycle ready/resolve: 3 cycles (FETCH, ISSUE, RESOLVE).

Reset
REQ-031 rst=0 asynchronously forces: state FETCH, pc=RESET_PC, pc_plus4=RESET_PC+4, instr=0, instr_valid=0, misaligned=0, retired=0; imem_req=1 from the first clock edge after rst releases.
REQ-032 Reset asserted mid-WAIT_MEM or mid-ISSUE abandons the transaction; a late imem_ack after release is consumed as the response to the new FETCH at RESET_PC.

Verification
REQ-033 Reset, imem_ack same cycle as req, ready=1, resolve with no control -> addresses 0,4,8 fetched; retired=3 after 9 cycles.
REQ-034 imem_ack delayed 4 cycles -> imem_req and imem_addr held constant 5 cycles; instr matches imem_rdata on ack cycle.
REQ-035 instr_ready low 3 cycles in ISSUE -> instr_valid stays 1, instr/pc unchanged; one handoff only.
REQ-036 pc=32'h100, Branch=1, func3=000, Zero=1, ImmExt=32'hFFFF_FFF0 -> next fetch 32'hF0; same with Zero=0 -> 32'h104; func3=010 -> 32'h104.
REQ-037 Jalr=1, ALUResult=32'h203 -> next fetch 32'h202 -> misaligned=1, state HALT, imem_req=0 thereafter; rst=0 clears.
REQ-038 Jump=1 at pc=32'hFFFF_FFFC, ImmExt=8 -> next fetch 32'h4; rst pulsed during WAIT_MEM -> next imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: single-issue instruction fetch sequencer.
// Fetches one word at pc, hands it to decode, waits for the execute stage to
// resolve its control outcome, then computes the next pc. A misaligned next
// pc sets a sticky flag and parks the unit in HALT until reset.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   imem_req/addr/ack/rdata  instruction memory request/response
//   instr, instr_valid       registered instruction handed to decode
//   instr_ready              decode accepts instr
//   pc, pc_plus4             address of issued instruction and address+4
//   resolve_valid            execute presents control outcome
//   Jump, Branch, Jalr       control decode of the issued instruction
//   func3, Zero, Neg         branch condition select and ALU flags
//   ImmExt, ALUResult        branch/jump offset; jalr target
//   misaligned               sticky misaligned-target flag
//   retired                  count of resolved instructions
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        resolve_valid,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        Jalr,
  input  logic [2:0]  func3,
  input  logic        Zero,
  input  logic        Neg,
  input  logic [31:0] ImmExt,
  input  logic [31:0] ALUResult,
  output logic        misaligned,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    FETCH,
    WAIT_MEM,
    ISSUE,
    RESOLVE,
    HALT
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        taken;
  logic [31:0] target;
  logic        target_ok;

  // Bit 0 of the jalr target is always forced to zero.
  logic        unused_alu_lsb;
  assign unused_alu_lsb = ALUResult[0];

  always_comb begin
    taken = 1'b0;
    case (func3)
      3'b000:  taken = Zero;
      3'b001:  taken = !Zero;
      3'b100:  taken = Neg;
      3'b101:  taken = !Neg;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    if (Jalr)
      target = {ALUResult[31:1], 1'b0};
    else if (Jump || (Branch && taken))
      target = pc + ImmExt;
    else
      target = pc_plus4;
  end

  assign target_ok = (target[1:0] == 2'b00);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= FETCH;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH, WAIT_MEM: state_nxt = imem_ack ? ISSUE : WAIT_MEM;
      ISSUE:           if (instr_ready) state_nxt = RESOLVE;
      RESOLVE:         if (resolve_valid) state_nxt = target_ok ? FETCH : HALT;
      HALT:            state_nxt = HALT;
      default:         state_nxt = FETCH;
    endcase
  end

  assign imem_req    = (state == FETCH) || (state == WAIT_MEM);
  assign imem_addr   = pc;
  assign instr_valid = (state == ISSUE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc         <= RESET_PC;
      pc_plus4   <= RESET_PC + 32'd4;
      instr      <= '0;
      misaligned <= 1'b0;
      retired    <= '0;
    end else begin
      case (state)
        FETCH, WAIT_MEM: begin
          if (imem_ack) instr <= imem_rdata;
        end
        RESOLVE: begin
          if (resolve_valid) begin
            retired <= retired + 32'd1;
            if (target_ok) begin
              pc       <= target;
              pc_plus4 <= target + 32'd4;
            end else begin
              misaligned <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// instruction stream checked against a transaction-level reference model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        resolve_valid = 1'b0;
  logic        Jump = 1'b0;
  logic        Branch = 1'b0;
  logic        Jalr = 1'b0;
  logic [2:0]  func3 = '0;
  logic        Zero = 1'b0;
  logic        Neg = 1'b0;
  logic [31:0] ImmExt = '0;
  logic [31:0] ALUResult = '0;
  logic        misaligned;
  logic [31:0] retired;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc(pc), .pc_plus4(pc_plus4),
    .resolve_valid(resolve_valid),
    .Jump(Jump), .Branch(Branch), .Jalr(Jalr),
    .func3(func3), .Zero(Zero), .Neg(Neg),
    .ImmExt(ImmExt), .ALUResult(ALUResult),
    .misaligned(misaligned), .retired(retired)
  );

  always #5 clk = ~clk;

  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned failed = 0;

  // Reference model state: one record per architectural quantity.
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_retired;
  logic        m_mis;
  logic        m_halt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Next pc from the instruction-set rules.
  function automatic logic [31:0] model_target(
    input logic [31:0] cur, input logic jl, input logic jp, input logic br,
    input logic [2:0] f3, input logic z, input logic n,
    input logic [31:0] imm, input logic [31:0] alu);
    bit tk;
    tk = (f3 == 3'd0 && z) || (f3 == 3'd1 && !z) || (f3 == 3'd4 && n) || (f3 == 3'd5 && !n);
    if (jl) return alu - (alu % 2);
    if (jp || (br && tk)) return cur + imm;
    return cur + 32'd4;
  endfunction

  task automatic do_reset();
    rst = 1'b0;
    imem_ack = 1'b0; instr_ready = 1'b0; resolve_valid = 1'b0;
    Jump = 1'b0; Branch = 1'b0; Jalr = 1'b0;
    #3;
    m_pc = RST_PC; m_instr = '0; m_retired = '0; m_mis = 1'b0; m_halt = 1'b0;
    chk("rst_pc", pc, m_pc);
    chk("rst_pc4", pc_plus4, m_pc + 32'd4);
    chk("rst_instr", instr, m_instr);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_mis", {31'd0, misaligned}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Memory answers after n wait cycles; request must stay steady meanwhile.
  task automatic do_fetch(input int unsigned n);
    chk("f_req", {31'd0, imem_req}, 32'd1);
    chk("f_addr", imem_addr, m_pc);
    chk("f_valid", {31'd0, instr_valid}, 32'd0);
    for (int unsigned i = 0; i < n; i++) begin
      imem_ack = 1'b0;
      imem_rdata = $urandom();
      @(negedge clk);
      chk("w_req", {31'd0, imem_req}, 32'd1);
      chk("w_addr", imem_addr, m_pc);
    end
    imem_ack = 1'b1;
    imem_rdata = $urandom();
    m_instr = imem_rdata;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("i_instr", instr, m_instr);
    chk("i_valid", {31'd0, instr_valid}, 32'd1);
    chk("i_pc", pc, m_pc);
    chk("i_pc4", pc_plus4, m_pc + 32'd4);
    chk("i_req", {31'd0, imem_req}, 32'd0);
  endtask

  // Decode stalls d cycles; stray acks and resolves must be ignored.
  task automatic do_issue(input int unsigned d);
    for (int unsigned i = 0; i < d; i++) begin
      instr_ready = 1'b0;
      imem_ack = 1'($urandom_range(0, 1));
      imem_rdata = $urandom();
      resolve_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("s_valid", {31'd0, instr_valid}, 32'd1);
      chk("s_instr", instr, m_instr);
      chk("s_pc", pc, m_pc);
    end
    imem_ack = 1'b0; resolve_valid = 1'b0;
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    chk("h_valid", {31'd0, instr_valid}, 32'd0);
    chk("h_req", {31'd0, imem_req}, 32'd0);
    chk("h_instr", instr, m_instr);
  endtask

  task automatic do_resolve(input int unsigned d, input logic jl, input logic jp,
                            input logic br, input logic [2:0] f3, input logic z,
                            input logic n, input logic [31:0] imm, input logic [31:0] alu);
    logic [31:0] t;
    for (int unsigned i = 0; i < d; i++) begin
      resolve_valid = 1'b0;
      imem_ack = 1'($urandom_range(0, 1));
      instr_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("r_retired", retired, m_retired);
      chk("r_req", {31'd0, imem_req}, 32'd0);
      chk("r_valid", {31'd0, instr_valid}, 32'd0);
    end
    imem_ack = 1'b0; instr_ready = 1'b0;
    Jalr = jl; Jump = jp; Branch = br; func3 = f3; Zero = z; Neg = n;
    ImmExt = imm; ALUResult = alu;
    resolve_valid = 1'b1;
    t = model_target(m_pc, jl, jp, br, f3, z, n, imm, alu);
    m_retired = m_retired + 32'd1;
    if (t % 4 == 0) m_pc = t;
    else begin m_mis = 1'b1; m_halt = 1'b1; end
    @(negedge clk);
    resolve_valid = 1'b0; Jalr = 1'b0; Jump = 1'b0; Branch = 1'b0;
    chk("x_retired", retired, m_retired);
    chk("x_mis", {31'd0, misaligned}, {31'd0, m_mis});
    chk("x_req", {31'd0, imem_req}, m_halt ? 32'd0 : 32'd1);
    chk("x_pc", pc, m_pc);
    if (!m_halt) chk("x_pc4", pc_plus4, m_pc + 32'd4);
  endtask

  task automatic plain(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      do_fetch(0);
      do_issue(0);
      do_resolve(0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    end
  endtask

  task automatic jump_to(input logic [31:0] dest);
    do_fetch(0);
    do_issue(0);
    do_resolve(0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, dest - m_pc, 32'd0);
  endtask

  task automatic halt_check(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      resolve_valid = 1'($urandom_range(0, 1));
      imem_ack = 1'($urandom_range(0, 1));
      instr_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("halt_req", {31'd0, imem_req}, 32'd0);
      chk("halt_mis", {31'd0, misaligned}, 32'd1);
      chk("halt_valid", {31'd0, instr_valid}, 32'd0);
      chk("halt_retired", retired, m_retired);
      chk("halt_pc", pc, m_pc);
    end
    resolve_valid = 1'b0; imem_ack = 1'b0; instr_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] r;
    logic [31:0] imm;
    logic [31:0] alu;

    @(negedge clk);
    do_reset();

    // Zero-wait stream: 0, 4, 8 fetched, three retired.
    plain(3);
    chk("three_retired", retired, 32'd3);
    chk("three_next_addr", imem_addr, 32'd12);

    // Slow memory, then slow decode.
    do_fetch(4);
    do_issue(3);
    do_resolve(2, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Branch cases at pc 0x100.
    jump_to(32'h100);
    do_fetch(0); do_issue(0);
    do_resolve(0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1, 1'b0, 32'hFFFF_FFF0, 32'd0);
    chk("beq_taken", imem_addr, 32'h0000_00F0);
    jump_to(32'h100);
    do_fetch(0); do_issue(0);
    do_resolve(0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0, 32'hFFFF_FFF0, 32'd0);
    chk("beq_not_taken", imem_addr, 32'h0000_0104);
    jump_to(32'h100);
    do_fetch(0); do_issue(0);
    do_resolve(0, 1'b0, 1'b0, 1'b1, 3'b010, 1'b1, 1'b1, 32'hFFFF_FFF0, 32'd0);
    chk("bad_func3", imem_addr, 32'h0000_0104);

    // Jump across the top of the address space.
    do_fetch(0); do_issue(0);
    do_resolve(0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 32'hFFFF_FFFD);
    chk("jalr_top", imem_addr, 32'hFFFF_FFFC);
    do_fetch(1); do_issue(0);
    do_resolve(0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 32'd8, 32'd0);
    chk("wrap_addr", imem_addr, 32'h0000_0004);

    // Reset in WAIT_MEM; an ack right after release answers the new fetch.
    chk("pre_wait_req", {31'd0, imem_req}, 32'd1);
    imem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #2;
    m_pc = RST_PC; m_instr = '0; m_retired = '0; m_mis = 1'b0; m_halt = 1'b0;
    chk("mid_rst_retired", retired, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hCAFE_0001;
    m_instr = imem_rdata;
    chk("post_rst_addr", imem_addr, RST_PC);
    @(negedge clk);
    imem_ack = 1'b0;
    chk("late_ack_instr", instr, m_instr);
    chk("late_ack_valid", {31'd0, instr_valid}, 32'd1);
    do_issue(1);
    do_resolve(0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0);

    // Misaligned jalr halts until reset.
    do_fetch(0); do_issue(0);
    do_resolve(0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 32'h0000_0203);
    halt_check(4);
    do_reset();
    chk("cleared_req", {31'd0, imem_req}, 32'd1);

    // Randomized stream against the model.
    for (int unsigned k = 0; k < 60; k++) begin
      if (m_halt) begin
        halt_check(2);
        do_reset();
      end else begin
        r = $urandom();
        imm = r & 32'hFFFF_FFFC;
        if ($urandom_range(0, 9) == 0) imm = imm | 32'd2;
        alu = $urandom();
        if ($urandom_range(0, 9) != 0) alu = alu & 32'hFFFF_FFFD;
        do_fetch($urandom_range(0, 3));
        do_issue($urandom_range(0, 2));
        do_resolve($urandom_range(0, 2),
                   1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), imm, alu);
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
